// File: rtl/vga_path_select.sv
// Aligns NUM_PATHS pixel streams of differing pipeline latency to the raw VGA timing,
// selects one for the pins and defers mode changes to a frame boundary.
// Optional feature macro: VGA_PATH_SWITCH_BLANK_EN (one black frame after each switch).
module vga_path_select #(
    parameter int                     NUM_PATHS = 4,
    parameter int                     DATA_W    = 8,
    parameter int                     MAX_LAT   = 4,
    parameter logic [NUM_PATHS*4-1:0] LAT_VEC   = {4'd4, 4'd2, 4'd0, 4'd0},
    localparam int                    SEL_W     = $clog2(NUM_PATHS)
) (
    input  logic                            clk_25_vga,
    input  logic                            rst_n,
    input  logic                            vsync,
    input  logic                            hsync,
    input  logic                            active_area,
    input  logic [NUM_PATHS*3*DATA_W-1:0]   path_data,
    input  logic [NUM_PATHS-1:0]            path_ready,
    input  logic [SEL_W-1:0]                mode_sel,
    output logic [DATA_W-1:0]               out_r,
    output logic [DATA_W-1:0]               out_g,
    output logic [DATA_W-1:0]               out_b,
    output logic                            out_hsync,
    output logic                            out_vsync,
    output logic                            out_active,
    output logic [SEL_W-1:0]                mode_cur,
    output logic                            switch_pending
);

    localparam int PIX_W = 3 * DATA_W;
    localparam int NSEL  = 1 << SEL_W;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_BLANK   = 2'd2
    } state_e;

    // Aligned per-path streams, padded to a power of two so the mux index is exact.
    logic [PIX_W-1:0] data_al [NSEL];
    logic [NSEL-1:0]  ready_al;

    for (genvar i = 0; i < NSEL; i++) begin : g_path
        if (i >= NUM_PATHS) begin : g_unused
            assign data_al[i]  = '0;
            assign ready_al[i] = 1'b0;
        end else begin : g_used
            localparam int DEPTH = MAX_LAT - int'(LAT_VEC[i*4 +: 4]);

            logic [PIX_W-1:0] data_in;
            logic             ready_in;

            assign data_in  = path_data[i*PIX_W +: PIX_W];
            assign ready_in = path_ready[i];

            if (DEPTH == 0) begin : g_wire
                assign data_al[i]  = data_in;
                assign ready_al[i] = ready_in;
            end else begin : g_regs
                logic [PIX_W-1:0] data_q  [DEPTH];
                logic             ready_q [DEPTH];

                always_ff @(posedge clk_25_vga or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int s = 0; s < DEPTH; s++) begin
                            data_q[s]  <= '0;
                            ready_q[s] <= 1'b0;
                        end
                    end else begin
                        data_q[0]  <= data_in;
                        ready_q[0] <= ready_in;
                        for (int s = 1; s < DEPTH; s++) begin
                            data_q[s]  <= data_q[s-1];
                            ready_q[s] <= ready_q[s-1];
                        end
                    end
                end

                assign data_al[i]  = data_q[DEPTH-1];
                assign ready_al[i] = ready_q[DEPTH-1];
            end
        end
    end

    // Raw timing delayed by the worst-case path latency; syncs idle high.
    logic vs_q  [MAX_LAT];
    logic hs_q  [MAX_LAT];
    logic act_q [MAX_LAT];
    logic vs_al;
    logic hs_al;
    logic act_al;

    always_ff @(posedge clk_25_vga or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < MAX_LAT; s++) begin
                vs_q[s]  <= 1'b1;
                hs_q[s]  <= 1'b1;
                act_q[s] <= 1'b0;
            end
        end else begin
            vs_q[0]  <= vsync;
            hs_q[0]  <= hsync;
            act_q[0] <= active_area;
            for (int s = 1; s < MAX_LAT; s++) begin
                vs_q[s]  <= vs_q[s-1];
                hs_q[s]  <= hs_q[s-1];
                act_q[s] <= act_q[s-1];
            end
        end
    end

    assign vs_al  = vs_q[MAX_LAT-1];
    assign hs_al  = hs_q[MAX_LAT-1];
    assign act_al = act_q[MAX_LAT-1];

    logic vs_prev_q;
    logic fb;

    always_ff @(posedge clk_25_vga or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b1;
        end else begin
            vs_prev_q <= vs_al;
        end
    end

    assign fb = vs_prev_q & ~vs_al;

    // Board switches are asynchronous to the pixel clock.
    logic [SEL_W-1:0] sel_meta_q;
    logic [SEL_W-1:0] req_q;
    logic             req_valid;

    always_ff @(posedge clk_25_vga or negedge rst_n) begin
        if (!rst_n) begin
            sel_meta_q <= '0;
            req_q      <= '0;
        end else begin
            sel_meta_q <= mode_sel;
            req_q      <= sel_meta_q;
        end
    end

    if (NSEL == NUM_PATHS) begin : g_all_valid
        assign req_valid = 1'b1;
    end else begin : g_range_valid
        assign req_valid = (req_q < SEL_W'(NUM_PATHS));
    end

    state_e           state_q;
    logic [SEL_W-1:0] mode_q;
    logic             pending_q;
    logic             blank_q;

    always_ff @(posedge clk_25_vga or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            mode_q    <= '0;
            pending_q <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (req_valid && (req_q != mode_q)) begin
                        state_q   <= ST_PENDING;
                        pending_q <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (!req_valid) begin
                        state_q   <= ST_RUN;
                        pending_q <= 1'b0;
                    end else if (fb) begin
                        pending_q <= 1'b0;
                        if (req_q == mode_q) begin
                            state_q <= ST_RUN;
                        end else begin
                            mode_q <= req_q;
`ifdef VGA_PATH_SWITCH_BLANK_EN
                            state_q <= ST_BLANK;
                            blank_q <= 1'b1;
`else
                            state_q <= ST_RUN;
`endif
                        end
                    end
                end
                ST_BLANK: begin
                    if (fb) begin
                        state_q <= ST_RUN;
                        blank_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    pending_q <= 1'b0;
                    blank_q   <= 1'b0;
                end
            endcase
        end
    end

    // Output register: the new mode_cur is first used the cycle after fb, still inside vsync.
    logic [PIX_W-1:0] pix_d;
    logic [PIX_W-1:0] out_pix_q;
    logic             out_hs_q;
    logic             out_vs_q;
    logic             out_act_q;

    always_comb begin
        pix_d = '0;
        if (act_al && ready_al[mode_q] && !blank_q) begin
            pix_d = data_al[mode_q];
        end
    end

    always_ff @(posedge clk_25_vga or negedge rst_n) begin
        if (!rst_n) begin
            out_pix_q <= '0;
            out_hs_q  <= 1'b1;
            out_vs_q  <= 1'b1;
            out_act_q <= 1'b0;
        end else begin
            out_pix_q <= pix_d;
            out_hs_q  <= hs_al;
            out_vs_q  <= vs_al;
            out_act_q <= act_al;
        end
    end

    assign out_r          = out_pix_q[3*DATA_W-1 -: DATA_W];
    assign out_g          = out_pix_q[2*DATA_W-1 -: DATA_W];
    assign out_b          = out_pix_q[DATA_W-1:0];
    assign out_hsync      = out_hs_q;
    assign out_vsync      = out_vs_q;
    assign out_active     = out_act_q;
    assign mode_cur       = mode_q;
    assign switch_pending = pending_q;

endmodule

// File: tb/tb_vga_path_select.sv
// Bench for vga_path_select: a 4-path default instance checked cycle by cycle against a
// history-based model, plus a 3-path instance for out-of-range switch requests.
module tb_vga_path_select;
    localparam int          NP   = 4;
    localparam int          DW   = 8;
    localparam int          ML   = 4;
    localparam logic [15:0] LV   = {4'd4, 4'd2, 4'd0, 4'd0};
    localparam int          NPB  = 3;
    localparam int          MLB  = 3;
    localparam logic [11:0] LVB  = {4'd3, 4'd1, 4'd0};
    localparam int          HT   = 20;
    localparam int          HA   = 12;
    localparam int          VA   = 6;
    localparam int          FT   = 200;
    localparam int          HIST = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b1, hsync = 1'b1, active = 1'b0;
    logic [NP*3*DW-1:0]  pdata = '0;
    logic [NP-1:0]       pready = '0;
    logic [1:0]          msel = '0;
    logic [NPB*3*DW-1:0] pdata_b = '0;
    logic [NPB-1:0]      pready_b = '0;
    logic [1:0]          msel_b = '0;

    logic [DW-1:0] out_r, out_g, out_b, out_r_b, out_g_b, out_b_b;
    logic out_hs, out_vs, out_act, pend, out_hs_b, out_vs_b, out_act_b, pend_b;
    logic [1:0] mode_cur, mode_cur_b;

    vga_path_select #(.NUM_PATHS(NP), .DATA_W(DW), .MAX_LAT(ML), .LAT_VEC(LV)) dut (
        .clk_25_vga(clk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync),
        .active_area(active), .path_data(pdata), .path_ready(pready), .mode_sel(msel),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_hsync(out_hs), .out_vsync(out_vs),
        .out_active(out_act), .mode_cur(mode_cur), .switch_pending(pend));

    vga_path_select #(.NUM_PATHS(NPB), .DATA_W(DW), .MAX_LAT(MLB), .LAT_VEC(LVB)) dut_b (
        .clk_25_vga(clk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync),
        .active_area(active), .path_data(pdata_b), .path_ready(pready_b), .mode_sel(msel_b),
        .out_r(out_r_b), .out_g(out_g_b), .out_b(out_b_b), .out_hsync(out_hs_b),
        .out_vsync(out_vs_b), .out_active(out_act_b), .mode_cur(mode_cur_b),
        .switch_pending(pend_b));

    always #5 clk = ~clk;

    // Raw per-cycle stimulus history, indexed by cycle number.
    bit         hv [HIST];
    bit         hh [HIST];
    bit         ha [HIST];
    logic [3:0] hr [HIST];
    logic [7:0] hb [HIST];
    logic [1:0] hsel [HIST];

    int n = 0, last_rst = 0, c0 = 0;
    int checks = 0, errors = 0;

    logic [1:0] m_mode = '0;
    bit         m_pend = 1'b0;
    bit         m_blank = 1'b0;

    typedef struct {
        int cycles; int sel; int selb; int rmode;
        int a_mode; int a_pend; int b_mode; int b_pend;
    } phase_t;
    phase_t tbl [13];

    function automatic bit ok(int k);
        return (k >= 0) && (k > last_rst);
    endfunction

    // Pixel carried by path k for raw cycle r: red is the raw pixel counter.
    function automatic logic [23:0] pix(int k, int r);
        logic [7:0] rc;
        if (r < 0) return '0;
        rc = r[7:0];
        return {rc, rc ^ (8'(k) << 4), hb[r] ^ 8'(k)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, got, exp);
        end
    endtask

    task automatic drive(input int sel, input int selb, input int rmode);
        int pos, line, col, rr, lk;
        pos  = (n - c0) % FT;
        line = pos / HT;
        col  = pos % HT;
        hv[n] = !(line == 7 || line == 8);
        hh[n] = !(col == 14 || col == 15);
        ha[n] = (line < VA) && (col < HA);
        hb[n] = 8'($urandom);
        case (rmode)
            1:       hr[n] = (line < 2) ? 4'b1101 : 4'hF;
            2:       for (int k = 0; k < 4; k++) hr[n][k] = ($urandom_range(0, 3) != 0);
            default: hr[n] = 4'hF;
        endcase
        hsel[n] = 2'(sel);
        vsync = hv[n]; hsync = hh[n]; active = ha[n];
        msel = 2'(sel); msel_b = 2'(selb);
        for (int k = 0; k < NP; k++) begin
            lk = int'(LV[k*4 +: 4]);
            rr = n - lk;
            pdata[k*24 +: 24] = pix(k, rr);
            pready[k] = (rr >= 0) ? hr[rr][k] : 1'b0;
        end
        for (int k = 0; k < NPB; k++) begin
            lk = int'(LVB[k*4 +: 4]);
            rr = n - lk;
            pdata_b[k*24 +: 24] = pix(k, rr);
            pready_b[k] = (rr >= 0) ? hr[rr][k] : 1'b0;
        end
        if (!rst_n) last_rst = n;
    endtask

    task automatic step();
        logic [23:0] e_pix;
        bit e_act, e_hs, e_vs, eb_act, eb_hs, eb_vs, fb;
        int r, rb;
        logic [1:0] req;
        @(posedge clk);
        #1;
        n++;
        if (!ok(n - 1)) begin
            e_pix = '0; e_act = 0; e_hs = 1; e_vs = 1; eb_act = 0; eb_hs = 1; eb_vs = 1;
        end else begin
            r  = n - 1 - ML;
            rb = n - 1 - MLB;
            e_act  = ok(r) && ha[r];
            e_hs   = !ok(r) || hh[r];
            e_vs   = !ok(r) || hv[r];
            e_pix  = (e_act && hr[r][m_mode] && !m_blank) ? pix(int'(m_mode), r) : '0;
            eb_act = ok(rb) && ha[rb];
            eb_hs  = !ok(rb) || hh[rb];
            eb_vs  = !ok(rb) || hv[rb];
        end
        if (!ok(n - 1)) begin
            m_mode = '0; m_pend = 0; m_blank = 0;
        end else begin
            req = ok(n - 3) ? hsel[n - 3] : 2'd0;
            fb  = (!ok(n - 6) || hv[n - 6]) && ok(n - 5) && !hv[n - 5];
            if (m_blank) begin
                if (fb) m_blank = 0;
            end else if (!m_pend) begin
                if (req != m_mode && int'(req) < NP) m_pend = 1;
            end else if (int'(req) >= NP) begin
                m_pend = 0;
            end else if (fb) begin
                m_pend = 0;
                if (req != m_mode) begin
                    m_mode = req;
`ifdef VGA_PATH_SWITCH_BLANK_EN
                    m_blank = 1;
`endif
                end
            end
        end
        chk("rgb", {out_r, out_g, out_b}, e_pix);
        chk("active", out_act, e_act);
        chk("hsync", out_hs, e_hs);
        chk("vsync", out_vs, e_vs);
        chk("mode_cur", mode_cur, m_mode);
        chk("switch_pending", pend, m_pend);
        chk("b_active", out_act_b, eb_act);
        chk("b_hsync", out_hs_b, eb_hs);
        chk("b_vsync", out_vs_b, eb_vs);
        if (!eb_act) chk("b_rgb_idle", {out_r_b, out_g_b, out_b_b}, 0);
    endtask

    task automatic run_phase(input int i);
        for (int j = 0; j < tbl[i].cycles; j++) begin
            drive(tbl[i].sel, tbl[i].selb, tbl[i].rmode);
            step();
        end
        chk("phase_mode", mode_cur, tbl[i].a_mode);
        chk("phase_pend", pend, tbl[i].a_pend);
        chk("phase_b_mode", mode_cur_b, tbl[i].b_mode);
        chk("phase_b_pend", pend_b, tbl[i].b_pend);
    endtask

    initial begin
        // cycles, sel, sel_b, ready pattern (0 all, 1 gate path1 lines 0-1, 2 random),
        // expected mode/pending of main and 3-path instance at phase end
        tbl[0]  = '{100, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{20,  2, 3, 0, 0, 1, 0, 0};
        tbl[2]  = '{60,  2, 3, 0, 2, 0, 0, 0};
        tbl[3]  = '{240, 2, 1, 0, 2, 0, 1, 0};
        tbl[4]  = '{30,  1, 3, 0, 2, 1, 1, 0};
        tbl[5]  = '{20,  2, 3, 0, 2, 1, 1, 0};
        tbl[6]  = '{200, 2, 2, 2, 2, 0, 2, 0};
        tbl[7]  = '{10,  1, 0, 0, 2, 1, 2, 1};
        tbl[8]  = '{10,  1, 3, 0, 2, 1, 2, 0};
        tbl[9]  = '{300, 1, 0, 1, 1, 0, 0, 0};
        tbl[10] = '{250, 3, 0, 2, 3, 0, 0, 0};
        tbl[11] = '{250, 3, 0, 2, 3, 0, 0, 0};
        tbl[12] = '{300, 3, 0, 0, 3, 0, 0, 0};

        for (int j = 0; j < 4; j++) begin
            drive(0, 0, 0);
            step();
        end
        chk("rst_r", out_r, 0);
        chk("rst_active", out_act, 0);
        chk("rst_syncs", {out_hs, out_vs}, 2'b11);
        chk("rst_mode", mode_cur, 0);
        chk("rst_pend", pend, 0);

        rst_n = 1'b1;
        c0 = n;
        for (int i = 0; i < 12; i++) run_phase(i);

        // Asynchronous reset in the middle of an active line, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        last_rst = n;
        #1;
        chk("async_rst_rgb", {out_r, out_g, out_b}, 0);
        chk("async_rst_active", out_act, 0);
        chk("async_rst_syncs", {out_hs, out_vs}, 2'b11);
        chk("async_rst_mode", mode_cur, 0);
        chk("async_rst_pend", pend, 0);
        chk("async_rst_b_mode", mode_cur_b, 0);
        for (int j = 0; j < 3; j++) begin
            drive(3, 0, 0);
            step();
        end
        rst_n = 1'b1;
        c0 = n;
        run_phase(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
